// File: rtl/tg_pkg.sv
// Shared types and defaults for the threadgroup tile controller.
//   tg_state_e : controller state encoding (IDLE/ISSUE/WAIT/OUT)
//   tg_res_t   : 16-bit signed FEDP result / partial sum
//   TG_*       : default parameter values for tg_controller
package tg_pkg;

    localparam int TG_AW     = 8;  // operand-buffer address width
    localparam int TG_KW     = 8;  // width of k_steps
    localparam int TG_RT_LAT = 3;  // rd_en to valid FEDP result, cycles
    localparam int TG_LANES  = 4;  // FEDPs per threadgroup tile

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } tg_state_e;

    typedef logic signed [15:0] tg_res_t;

endpackage

// File: rtl/tg_controller.sv
// Sequencer for one threadgroup tile of four FEDPs.
// Walks k_steps 4-element chunks: each chunk issues one operand-buffer read,
// waits RT_LAT cycles for the FEDP results and captures them as the partial
// sums fed back for the next chunk. The final sums are offered on a
// valid/ready output.
// Ports:
//   clk, rstn            clock, synchronous active-low reset
//   start, k_steps,      tile request from the dispatcher (IDLE only)
//   base_addr
//   busy                 high whenever not IDLE
//   rd_en, rd_addr       read strobe/address to both operand buffers
//   psum0..3             partial sums to the FEDPs (= accumulators)
//   res0..3              FEDP results
//   out_valid/out_ready  tile result handshake
//   out_data0..3         tile results, lane n = FEDP n
// All outputs come straight from flops.
module tg_controller
    import tg_pkg::*;
#(
    parameter int AW     = TG_AW,
    parameter int KW     = TG_KW,
    parameter int RT_LAT = TG_RT_LAT
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [KW-1:0]        k_steps,
    input  logic [AW-1:0]        base_addr,
    output logic                 busy,
    output logic                 rd_en,
    output logic [AW-1:0]        rd_addr,
    output logic signed [15:0]   psum0,
    output logic signed [15:0]   psum1,
    output logic signed [15:0]   psum2,
    output logic signed [15:0]   psum3,
    input  logic signed [15:0]   res0,
    input  logic signed [15:0]   res1,
    input  logic signed [15:0]   res2,
    input  logic signed [15:0]   res3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [15:0]   out_data0,
    output logic signed [15:0]   out_data1,
    output logic signed [15:0]   out_data2,
    output logic signed [15:0]   out_data3
);

    localparam int CW = $clog2(RT_LAT + 1);

    tg_state_e               state, state_nxt;
    logic [KW-1:0]           k_reg, step;
    logic [AW-1:0]           addr_reg;
    logic [CW-1:0]           cnt;
    tg_res_t [TG_LANES-1:0]  acc;
    logic [TG_LANES-1:0][15:0] res_vec;

    logic                    capture, last;
    logic                    busy_nxt, rd_en_nxt, out_valid_nxt;
    logic [AW-1:0]           rd_addr_nxt;

    assign res_vec = {res3, res2, res1, res0};

    // Counter is loaded with RT_LAT in ISSUE and counts down through WAIT;
    // the cycle it steps 1 -> 0 is exactly RT_LAT cycles after rd_en.
    assign capture = (state == WAIT) && (cnt == CW'(1));
    assign last    = (step == k_reg - KW'(1));

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (k_steps != '0) ? ISSUE : OUT;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (capture) state_nxt = last ? OUT : ISSUE;
            OUT:     if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- output decode (registered below) ----------------
    // Outputs are decoded from the next state so they appear in the same
    // cycle as the state they describe while still leaving a flop.
    always_comb begin
        busy_nxt      = (state_nxt != IDLE);
        rd_en_nxt     = (state_nxt == ISSUE);
        out_valid_nxt = (state_nxt == OUT);
        rd_addr_nxt   = rd_addr;
        if (state == IDLE && start)
            rd_addr_nxt = base_addr;
        else if (capture && !last)
            rd_addr_nxt = addr_reg + AW'(step) + AW'(1);
    end

    // ---------------- output and datapath registers ----------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            k_reg     <= '0;
            addr_reg  <= '0;
            step      <= '0;
            cnt       <= '0;
            acc       <= '0;
        end else begin
            busy      <= busy_nxt;
            rd_en     <= rd_en_nxt;
            rd_addr   <= rd_addr_nxt;
            out_valid <= out_valid_nxt;
            case (state)
                IDLE: if (start) begin
                    k_reg    <= k_steps;
                    addr_reg <= base_addr;
                    step     <= '0;
                    acc      <= '0;
                end
                ISSUE: cnt <= CW'(RT_LAT);
                WAIT: begin
                    cnt <= cnt - CW'(1);
                    if (capture) begin
                        acc <= res_vec;
                        if (!last) step <= step + KW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Accumulators are constant from ISSUE through capture and through OUT,
    // so they serve directly as both the partial sums and the tile result.
    assign psum0     = acc[0];
    assign psum1     = acc[1];
    assign psum2     = acc[2];
    assign psum3     = acc[3];
    assign out_data0 = acc[0];
    assign out_data1 = acc[1];
    assign out_data2 = acc[2];
    assign out_data3 = acc[3];

endmodule

// File: tb/tb_tg_controller.sv
module tb_tg_controller;
    import tg_pkg::*;

    localparam int L = 3;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic out_ready = 1'b0;
    logic [7:0] k_steps = '0;
    logic [7:0] base_addr = '0;
    logic signed [15:0] res0 = '0, res1 = '0, res2 = '0, res3 = '0;

    logic busy, rd_en, out_valid;
    logic [7:0] rd_addr;
    logic signed [15:0] psum0, psum1, psum2, psum3;
    logic signed [15:0] out_data0, out_data1, out_data2, out_data3;

    logic busy4, rd_en4, out_valid4;
    logic [3:0] rd_addr4;
    logic signed [15:0] p4 [4];
    logic signed [15:0] od4 [4];

    always #5 clk = ~clk;

    tg_controller #(.AW(8), .KW(8), .RT_LAT(L)) dut (
        .clk(clk), .rstn(rstn), .start(start), .k_steps(k_steps), .base_addr(base_addr),
        .busy(busy), .rd_en(rd_en), .rd_addr(rd_addr),
        .psum0(psum0), .psum1(psum1), .psum2(psum2), .psum3(psum3),
        .res0(res0), .res1(res1), .res2(res2), .res3(res3),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3)
    );

    // Narrow-address copy sharing every input: exercises rd_addr wrap at AW=4.
    tg_controller #(.AW(4), .KW(8), .RT_LAT(L)) dut4 (
        .clk(clk), .rstn(rstn), .start(start), .k_steps(k_steps), .base_addr(base_addr[3:0]),
        .busy(busy4), .rd_en(rd_en4), .rd_addr(rd_addr4),
        .psum0(p4[0]), .psum1(p4[1]), .psum2(p4[2]), .psum3(p4[3]),
        .res0(res0), .res1(res1), .res2(res2), .res3(res3),
        .out_valid(out_valid4), .out_ready(out_ready),
        .out_data0(od4[0]), .out_data1(od4[1]), .out_data2(od4[2]), .out_data3(od4[3])
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per-chunk product sums d[chunk][lane] for the current tile.
    logic [15:0] dtab [0:15][0:3];

    int          cyc = 0;
    bit          m_busy = 1'b0;
    bit          m_rst = 1'b0;
    int          t0 = 0;
    int          mk = 0;
    logic [7:0]  mbase = '0;
    logic [15:0] macc [4];

    function automatic logic [15:0] dsum(input int n, input int upto);
        logic [15:0] s;
        s = '0;
        for (int j = 0; j < upto; j++) s = s + dtab[j][n];
        return s;
    endfunction

    // Tile timeline: chunk i occupies cycles t0+1+i*(L+1) .. t0+(i+1)*(L+1),
    // output phase follows until the handshake.
    always @(posedge clk) begin : model_step
        int rel;
        rel = cyc - t0;
        if (!rstn) begin
            m_busy = 1'b0;
            m_rst  = 1'b1;
            for (int n = 0; n < 4; n++) macc[n] = '0;
        end else begin
            m_rst = 1'b0;
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1'b1;
                    t0     = cyc;
                    mk     = int'(k_steps);
                    mbase  = base_addr;
                    for (int n = 0; n < 4; n++) macc[n] = '0;
                end
            end else if (rel >= 1 + mk * (L + 1) && out_ready) begin
                m_busy = 1'b0;
                for (int n = 0; n < 4; n++) macc[n] = dsum(n, mk);
            end
        end
        cyc = cyc + 1;
    end

    // FEDP model: result = psum + d, delivered L cycles after rd_en;
    // garbage on res in every other cycle.
    typedef struct {
        int               due;
        logic [3:0][15:0] v;
    } fe_t;
    fe_t fq[$];

    always @(negedge clk) begin : fedp
        fe_t e;
        int  i;
        logic [15:0] ps [4];
        while (fq.size() > 0 && fq[0].due < cyc) void'(fq.pop_front());
        if (fq.size() > 0 && fq[0].due == cyc) begin
            res0 = fq[0].v[0]; res1 = fq[0].v[1]; res2 = fq[0].v[2]; res3 = fq[0].v[3];
        end else begin
            res0 = 16'($urandom); res1 = 16'($urandom); res2 = 16'($urandom); res3 = 16'($urandom);
        end
        if (rd_en === 1'b1) begin
            i = m_busy ? (cyc - t0 - 1) / (L + 1) : 0;
            if (i < 0) i = 0;
            if (i > 15) i = 15;
            ps[0] = psum0; ps[1] = psum1; ps[2] = psum2; ps[3] = psum3;
            e.due = cyc + L;
            for (int n = 0; n < 4; n++) e.v[n] = ps[n] + dtab[i][n];
            fq.push_back(e);
        end
    end

    // Compare process: every cycle, all outputs of both instances.
    always @(negedge clk) begin : compare
        int rel, i, ph;
        logic e_busy, e_rd, e_valid;
        logic [7:0] e_addr;
        logic [15:0] e_ps [4];
        logic [15:0] a_ps [4];
        logic [15:0] a_od [4];
        if (cyc > 0) begin
            e_rd = 1'b0; e_valid = 1'b0; e_addr = '0; e_busy = m_busy;
            for (int n = 0; n < 4; n++) e_ps[n] = macc[n];
            if (m_busy) begin
                rel = cyc - t0;
                if (rel < 1 + mk * (L + 1)) begin
                    i  = (rel - 1) / (L + 1);
                    ph = (rel - 1) % (L + 1);
                    e_rd   = (ph == 0);
                    e_addr = mbase + 8'(i);
                    for (int n = 0; n < 4; n++) e_ps[n] = dsum(n, i);
                end else begin
                    e_valid = 1'b1;
                    for (int n = 0; n < 4; n++) e_ps[n] = dsum(n, mk);
                end
            end
            a_ps[0] = psum0; a_ps[1] = psum1; a_ps[2] = psum2; a_ps[3] = psum3;
            a_od[0] = out_data0; a_od[1] = out_data1; a_od[2] = out_data2; a_od[3] = out_data3;
            chk("busy", 16'(busy), 16'(e_busy));
            chk("rd_en", 16'(rd_en), 16'(e_rd));
            chk("out_valid", 16'(out_valid), 16'(e_valid));
            chk("busy4", 16'(busy4), 16'(e_busy));
            chk("rd_en4", 16'(rd_en4), 16'(e_rd));
            chk("out_valid4", 16'(out_valid4), 16'(e_valid));
            for (int n = 0; n < 4; n++) chk($sformatf("psum%0d", n), a_ps[n], e_ps[n]);
            if (e_rd) begin
                chk("rd_addr", 16'(rd_addr), 16'(e_addr));
                chk("rd_addr4", 16'(rd_addr4), 16'(e_addr[3:0]));
            end
            if (e_valid || m_rst)
                for (int n = 0; n < 4; n++) begin
                    chk($sformatf("out_data%0d", n), a_od[n], e_ps[n]);
                    chk($sformatf("out_data4_%0d", n), 16'(od4[n]), e_ps[n]);
                end
            if (m_rst) begin
                chk("rst_rd_addr", 16'(rd_addr), 16'h0);
                chk("rst_rd_addr4", 16'(rd_addr4), 16'h0);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Starts a tile from IDLE, waits for out_valid, applies `hold` cycles of
    // backpressure, then handshakes. spam pulses start (and scrambles the
    // request fields) while busy.
    task automatic tile(input int k, input logic [7:0] b, input int hold, input bit spam,
                        output int lat, output int nrd, output int first_a, output int last_a4);
        bit got;
        lat = 0; nrd = 0; first_a = -1; last_a4 = -1; got = 1'b0;
        k_steps = 8'(k); base_addr = b; start = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 400; c++) begin
            if (out_valid === 1'b1) begin
                lat = c; got = 1'b1;
                break;
            end
            if (rd_en === 1'b1) begin
                nrd++;
                if (first_a < 0) first_a = int'(rd_addr);
            end
            if (rd_en4 === 1'b1) last_a4 = int'(rd_addr4);
            if (spam) begin
                start = 1'($urandom); k_steps = 8'($urandom); base_addr = 8'($urandom);
            end
            @(negedge clk);
        end
        if (!got) chk("out_valid_timeout", 16'(got), 16'h1);
        for (int h = 0; h < hold; h++) begin
            start = spam ? 1'($urandom) : 1'b0;
            out_ready = 1'b0;
            @(negedge clk);
        end
        out_ready = 1'b1;
        start = spam;
        @(negedge clk);
        out_ready = 1'b0;
        start = 1'b0;
        chk("idle_after_hs", 16'(busy), 16'h0);
    endtask

    initial begin : stim
        int lat, nrd, fa, la4;
        repeat (2) @(negedge clk);
        // reset state
        chk("reset_busy", 16'(busy), 16'h0);
        chk("reset_rd_en", 16'(rd_en), 16'h0);
        chk("reset_valid", 16'(out_valid), 16'h0);
        chk("reset_psum0", psum0, 16'h0);
        rstn = 1'b1;

        // k=1, base=5, d=10
        for (int n = 0; n < 4; n++) dtab[0][n] = 16'd10;
        tile(1, 8'd5, 0, 1'b0, lat, nrd, fa, la4);
        chk("t1_latency", 16'(lat), 16'd5);
        chk("t1_nrd", 16'(nrd), 16'd1);
        chk("t1_addr", 16'(fa), 16'd5);
        chk("t1_psum_idle", psum3, 16'd10);

        // k=4, base=0, d_n=n+1 -> out_data_n = 4(n+1)
        for (int j = 0; j < 16; j++) for (int n = 0; n < 4; n++) dtab[j][n] = 16'(n + 1);
        tile(4, 8'd0, 0, 1'b0, lat, nrd, fa, la4);
        chk("t2_latency", 16'(lat), 16'd17);
        chk("t2_nrd", 16'(nrd), 16'd4);
        chk("t2_data0", macc[0], 16'd4);
        chk("t2_data3", macc[3], 16'd16);

        // k=0
        k_steps = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("k0_valid_c1", 16'(out_valid), 16'h1);
        chk("k0_busy_c1", 16'(busy), 16'h1);
        chk("k0_data", out_data2, 16'h0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("k0_idle", 16'(busy), 16'h0);

        // backpressure with start spam
        for (int j = 0; j < 16; j++) for (int n = 0; n < 4; n++) dtab[j][n] = 16'($urandom);
        tile(2, 8'd40, 10, 1'b1, lat, nrd, fa, la4);
        chk("bp_nrd", 16'(nrd), 16'd2);

        // AW=4 wrap: 14, 15, 0
        tile(3, 8'd14, 1, 1'b0, lat, nrd, fa, la4);
        chk("wrap_first", 16'(fa), 16'd14);
        chk("wrap_last4", 16'(la4), 16'd0);

        // reset during WAIT of chunk 2 of a k=4 tile
        for (int j = 0; j < 16; j++) for (int n = 0; n < 4; n++) dtab[j][n] = 16'($urandom);
        k_steps = 8'd4; base_addr = 8'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("mid_rst_busy", 16'(busy), 16'h0);
        chk("mid_rst_rd_en", 16'(rd_en), 16'h0);
        chk("mid_rst_addr", 16'(rd_addr), 16'h0);
        chk("mid_rst_psum1", psum1, 16'h0);
        chk("mid_rst_valid", 16'(out_valid), 16'h0);
        chk("mid_rst_data0", out_data0, 16'h0);
        for (int n = 0; n < 4; n++) dtab[0][n] = 16'd100 + 16'(n);
        tile(1, 8'd7, 0, 1'b0, lat, nrd, fa, la4);
        chk("post_rst_data0", macc[0], 16'd100);
        chk("post_rst_data3", macc[3], 16'd103);

        // randomized tiles
        for (int t = 0; t < 30; t++) begin
            for (int j = 0; j < 16; j++) for (int n = 0; n < 4; n++) dtab[j][n] = 16'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            tile(int'($urandom_range(0, 6)), 8'($urandom), int'($urandom_range(0, 4)),
                 1'($urandom), lat, nrd, fa, la4);
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
